// File: rtl/nibble_serial_add16.sv
// Nibble-serial adder: one 4-bit full adder walks the operands LSB nibble
// first, producing a registered W-bit sum and carry-out.

module full_add_4bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_carry
);

    assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {4'd0, i_cin};

endmodule

module nibble_serial_add16 #(
    parameter int NIBBLES = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [4*NIBBLES-1:0] i_a,
    input  logic [4*NIBBLES-1:0] i_b,
    input  logic                 i_cin,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [4*NIBBLES-1:0] o_sum,
    output logic                 o_carry
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [IW-1:0] idx;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          carry_q;
    logic [W-1:0]  partial;
    logic [W-1:0]  full;
    logic [3:0]    fa_sum;
    logic          fa_carry;

    full_add_4bit u_fa (
        .i_a    (a_q[4*idx +: 4]),
        .i_b    (b_q[4*idx +: 4]),
        .i_cin  (carry_q),
        .o_sum  (fa_sum),
        .o_carry(fa_carry)
    );

    // partial with the nibble being computed this cycle already merged in
    always_comb begin
        full = partial;
        full[4*idx +: 4] = fa_sum;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (i_start) state_n = RUN;
            RUN:     if (idx == LAST) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            idx     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            partial <= '0;
            o_sum   <= '0;
            o_carry <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        a_q     <= i_a;
                        b_q     <= i_b;
                        carry_q <= i_cin;
                        idx     <= '0;
                    end
                end
                RUN: begin
                    partial[4*idx +: 4] <= fa_sum;
                    carry_q             <= fa_carry;
                    if (idx == LAST) begin
                        o_sum   <= full;
                        o_carry <= fa_carry;
                        idx     <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: idx <= '0;
            endcase
        end
    end

    assign o_busy = (state != IDLE);
    assign o_done = (state == DONE);

endmodule

// File: tb/tb_nibble_serial_add16.sv
// Directed and random checks of nibble_serial_add16 at NIBBLES=4 and
// NIBBLES=1, against hand-computed vectors and an A+B+cin model.

module tb_nibble_serial_add16;

    logic        clk = 1'b0;
    logic        rst;

    logic        start16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        cin16;
    logic        busy16;
    logic        done16;
    logic [15:0] sum16;
    logic        carry16;

    logic        start4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        cin4;
    logic        busy4;
    logic        done4;
    logic [3:0]  sum4;
    logic        carry4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nibble_serial_add16 #(.NIBBLES(4)) dut16 (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_start(start16),
        .i_a    (a16),
        .i_b    (b16),
        .i_cin  (cin16),
        .o_busy (busy16),
        .o_done (done16),
        .o_sum  (sum16),
        .o_carry(carry16)
    );

    nibble_serial_add16 #(.NIBBLES(1)) dut4 (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_start(start4),
        .i_a    (a4),
        .i_b    (b4),
        .i_cin  (cin4),
        .o_busy (busy4),
        .o_done (done4),
        .o_sum  (sum4),
        .o_carry(carry4)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        carry;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one addition into the selected DUT (sel=1: NIBBLES=1).
    // edges counts the accepting edge plus the edges up to o_done.
    task automatic run_op(input bit sel, input logic [15:0] a,
                          input logic [15:0] b, input logic cin,
                          output logic [15:0] s, output logic c,
                          output int edges, output int busy_cnt);
        logic dn;
        if (sel) begin
            a4 = a[3:0]; b4 = b[3:0]; cin4 = cin; start4 = 1'b1;
        end else begin
            a16 = a; b16 = b; cin16 = cin; start16 = 1'b1;
        end
        tick();
        start16 = 1'b0;
        start4  = 1'b0;
        edges    = 1;
        busy_cnt = 0;
        dn = sel ? done4 : done16;
        busy_cnt += int'(sel ? busy4 : busy16);
        while (!dn && edges < 20) begin
            tick();
            edges++;
            dn = sel ? done4 : done16;
            busy_cnt += int'(sel ? busy4 : busy16);
        end
        if (!dn) check("done_timeout", 0, 1);
        s = sel ? {12'd0, sum4} : sum16;
        c = sel ? carry4 : carry16;
    endtask

    logic [15:0] s;
    logic        c;
    int          e;
    int          bc;
    logic [16:0] model;
    int          gap;

    initial begin
        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
        vecs[2] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1};
        vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[5] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1};
        vecs[6] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
        vecs[7] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};

        start16 = 0; a16 = 0; b16 = 0; cin16 = 0;
        start4 = 0; a4 = 0; b4 = 0; cin4 = 0;
        rst = 1'b1;
        tick();
        tick();
        check("rst_busy", busy16, 0);
        check("rst_done", done16, 0);
        check("rst_sum", sum16, 0);
        check("rst_carry", carry16, 0);
        rst = 1'b0;

        // table vectors, first one starts on the first edge after reset
        for (int i = 0; i < 8; i++) begin
            run_op(0, vecs[i].a, vecs[i].b, vecs[i].cin, s, c, e, bc);
            check($sformatf("vec%0d_sum", i), s, vecs[i].sum);
            check($sformatf("vec%0d_carry", i), c, vecs[i].carry);
            check($sformatf("vec%0d_edges", i), e, 5);
            check($sformatf("vec%0d_busy", i), bc, 5);
            tick();
            check($sformatf("vec%0d_done_pulse", i), done16, 0);
            check($sformatf("vec%0d_idle", i), busy16, 0);
            check($sformatf("vec%0d_hold", i), sum16, vecs[i].sum);
        end

        // start held high, operands toggled during RUN
        a16 = 16'h1234; b16 = 16'h4321; cin16 = 1'b1; start16 = 1'b1;
        tick();
        e = 1;
        while (!done16 && e < 20) begin
            a16 = ~a16; b16 = b16 + 16'h0101; cin16 = ~cin16;
            check("hold_busy", busy16, 1);
            tick();
            e++;
        end
        check("hold_edges", e, 5);
        check("hold_sum", sum16, 16'h5556);
        check("hold_carry", carry16, 0);
        a16 = 16'h0001; b16 = 16'h0002; cin16 = 1'b0;
        tick();
        check("hold_idle", busy16, 0);
        check("hold_keep_sum", sum16, 16'h5556);
        tick();
        start16 = 1'b0;
        check("hold_restart", busy16, 1);
        e = 0;
        while (!done16 && e < 20) begin
            check("hold_sum_run", sum16, 16'h5556);
            tick();
            e++;
        end
        check("second_sum", sum16, 16'h0003);
        tick();

        // back-to-back starts: done pulses NIBBLES+2 cycles apart
        a16 = 16'h8000; b16 = 16'h8000; cin16 = 1'b1; start16 = 1'b1;
        e = 0;
        while (!done16 && e < 20) begin tick(); e++; end
        check("b2b_sum1", sum16, 16'h0001);
        check("b2b_carry1", carry16, 1);
        gap = 0;
        tick();
        gap++;
        while (!done16 && gap < 20) begin tick(); gap++; end
        start16 = 1'b0;
        check("b2b_gap", gap, 6);
        check("b2b_sum2", sum16, 16'h0001);
        check("b2b_carry2", carry16, 1);
        tick();

        // async reset two edges into RUN
        a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b0; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy16, 0);
        check("abort_done", done16, 0);
        check("abort_sum", sum16, 0);
        check("abort_carry", carry16, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_no_done", done16, 0);
        end
        rst = 1'b0;
        run_op(0, 16'h1234, 16'h4321, 1'b1, s, c, e, bc);
        check("after_rst_sum", s, 16'h5556);
        check("after_rst_carry", c, 0);
        check("after_rst_edges", e, 5);
        tick();

        // random vectors, NIBBLES=4
        for (int i = 0; i < 200; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic        rc;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            model = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
            run_op(0, ra, rb, rc, s, c, e, bc);
            check("rand16", {c, s}, model);
            tick();
        end

        // NIBBLES=1
        run_op(1, 16'h000F, 16'h0001, 1'b0, s, c, e, bc);
        check("n1_sum", s, 0);
        check("n1_carry", c, 1);
        check("n1_edges", e, 2);
        check("n1_busy", bc, 2);
        tick();
        check("n1_idle", busy4, 0);
        for (int i = 0; i < 200; i++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            logic       rc;
            ra = 4'($urandom);
            rb = 4'($urandom);
            rc = 1'($urandom);
            model = {12'd0, {1'b0, ra} + {1'b0, rb} + {4'd0, rc}};
            run_op(1, {12'd0, ra}, {12'd0, rb}, rc, s, c, e, bc);
            check("rand4", {c, s[3:0]}, model[4:0]);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_serial_add16.md
NIBBLE_SERIAL_ADD16 -- requirements
Module: nibble_serial_add16

Interface
REQ-001 SHALL provide parameter NIBBLES, default 4, number of 4-bit nibbles per operand (operand width W = 4*NIBBLES; legal range 1..8).
REQ-002 SHALL provide port i_clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL provide port i_rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL provide port i_start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 SHALL provide port i_a  input  W  operand A, captured on the accepting edge.
REQ-006 SHALL provide port i_b  input  W  operand B, captured on the accepting edge.
REQ-007 SHALL provide port i_cin  input  1  carry-in, captured on the accepting edge.
REQ-008 SHALL provide port o_busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL provide port o_done  output  1  one-cycle pulse marking a valid result.
REQ-010 SHALL provide port o_sum  output  W  registered result of A+B+cin, modulo 2^W.
REQ-011 SHALL provide port o_carry  output  1  registered carry-out of bit W-1.

Function
REQ-012 SHALL instantiate exactly one full_add_4bit (i_a, i_b, i_cin, o_sum, o_carry) and compute the W-bit sum nibble-serially, least significant nibble first.
REQ-013 SHALL implement three states: IDLE, RUN, DONE.
REQ-014 IDLE: on an edge with i_start=1, SHALL capture i_a, i_b, i_cin, clear nibble index to 0, load the internal carry with i_cin, go to RUN; i_start=0 stays IDLE.
REQ-015 RUN: the adder SHALL be driven with nibble[idx] of A and B plus the internal carry; each edge writes the adder sum into partial[4*idx+3:4*idx], loads the internal carry with the adder carry, and increments idx.
REQ-016 RUN: on the edge processing idx = NIBBLES-1, SHALL load o_sum with the complete partial result, load o_carry with the adder carry, and go to DONE.
REQ-017 DONE: o_done SHALL be 1 for exactly this one cycle; the next edge SHALL return to IDLE.
REQ-018 Latency: o_done SHALL be high in the cycle that begins NIBBLES+1 edges after the accepting edge (5 edges when NIBBLES=4); throughput one addition per NIBBLES+2 cycles.
REQ-019 i_start SHALL be ignored in RUN and DONE; no queuing; the captured operands SHALL NOT change mid-operation even if the i_a/i_b/i_cin inputs toggle.
REQ-020 o_sum/o_carry SHALL change only on the RUN->DONE edge and SHALL hold the last result otherwise, including through later IDLE and RUN periods.
REQ-021 o_busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-022 With NIBBLES=1, RUN SHALL last exactly one cycle, then DONE.
REQ-023 The index counter SHALL never exceed NIBBLES-1, and no unused state SHALL be reachable; any illegal encoding SHALL return to IDLE on the next edge.

Reset
REQ-024 Asserting i_rst SHALL immediately force IDLE, idx=0, internal carry=0, partial=0, o_sum=0, o_carry=0, o_done=0, o_busy=0, independent of i_clk.
REQ-025 Reset during RUN or DONE SHALL abort the operation: no o_done pulse, and o_sum/o_carry read 0.
REQ-026 The first edge after reset deasserts SHALL accept i_start normally.

Verification
REQ-027 A=0xFFFF, B=0x0001, cin=0, one-cycle start -> o_busy high for 5 cycles, o_done pulse 5 edges after acceptance, o_sum=0x0000, o_carry=1.
REQ-028 A=0x1234, B=0x4321, cin=1 -> o_sum=0x5556, o_carry=0; hold i_start high and toggle operands during RUN -> second addition starts only after return to IDLE, and the result is unaffected.
REQ-029 Start, then assert i_rst during RUN (after 2 edges) -> o_done never pulses, all outputs read 0 immediately, and the next start completes correctly.
REQ-030 Back-to-back starts (i_start held high): A=0x8000, B=0x8000, cin=1 -> o_sum=0x0001, o_carry=1; o_done pulses are exactly NIBBLES+2 cycles apart.
REQ-031 200 random {A,B,cin} vectors, each compared at o_done against the model {carry,sum}=A+B+cin -> zero mismatches; repeat with NIBBLES=1 (A=0xF, B=0x1, cin=0 -> sum=0x0, carry=1, done 2 edges after acceptance).
